// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access unit: datapath width,
// funct3 size/sign encodings, FSM states and the writeback bundle.
package mem_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE
    } mem_state_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_data;
    } wb_bundle_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and replication, load
// extraction with sign/zero extension, and the misalignment check.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]        lane,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_beat,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_value,
    output logic              misaligned
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] wdata_b;
    logic [XLEN-1:0] wdata_h;
    logic [XLEN-1:0] wdata_w;

    assign shifted = load_beat >> {lane, 3'b000};

    // Each byte lane picks the store byte that lands there once replicated.
    generate
        for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_lane
            assign wdata_b[gi*8 +: 8] = store_data[7:0];
            assign wdata_h[gi*8 +: 8] = store_data[(gi%2)*8 +: 8];
            assign wdata_w[gi*8 +: 8] = store_data[(gi%4)*8 +: 8];
        end
    endgenerate

    always_comb begin
        wstrb = '0;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin wstrb = 8'h01 << lane; wdata = wdata_b; end
            2'b01: begin wstrb = 8'h03 << lane; wdata = wdata_h; end
            2'b10: begin wstrb = 8'h0F << lane; wdata = wdata_w; end
            default: begin wstrb = 8'hFF; wdata = store_data; end
        endcase
    end

    always_comb begin
        load_value = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B:  load_value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU: load_value = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H: begin
                load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned = lane[0];
            end
            F3_HU: begin
                load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misaligned = lane[0];
            end
            F3_W: begin
                load_value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                misaligned = (lane[1:0] != 2'b00);
            end
            F3_WU: begin
                load_value = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misaligned = (lane[1:0] != 2'b00);
            end
            F3_D: begin
                load_value = load_beat;
                misaligned = (lane != 3'b000);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues one handshaked data-memory transaction per
// load/store, stalls upstream meanwhile, and builds the MEM/WB bundle.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_addr,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [XLEN/8-1:0] dmem_req_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_rdata,
    output logic              stall_out,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_alu_result,
    output logic [XLEN-1:0]   wb_load_data,
    output logic              misalign_fault
);

    mem_state_t      state_reg, state_next;
    logic [XLEN-1:0] load_reg;
    logic [XLEN-1:0] load_value;
    logic            misaligned;
    logic            mem_op;
    wb_bundle_t      wb;

    assign mem_op = ex_valid && (ex_mem_read || ex_mem_write);

    mem_align u_align (
        .lane       (ex_addr[2:0]),
        .funct3     (ex_funct3),
        .store_data (ex_store_data),
        .load_beat  (dmem_resp_rdata),
        .wstrb      (dmem_req_wstrb),
        .wdata      (dmem_req_wdata),
        .load_value (load_value),
        .misaligned (misaligned)
    );

    // EX inputs are frozen by the stall, so request fields come straight from them.
    assign dmem_req_we   = ex_mem_write;
    assign dmem_req_addr = {ex_addr[XLEN-1:3], 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            load_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT_RESP && dmem_resp_valid)
                load_reg <= load_value;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    if (dmem_req_ready)
                        state_next = ex_mem_write ? DONE : WAIT_RESP;
                    else
                        state_next = REQ;
                end
            end
            REQ: begin
                if (dmem_req_ready)
                    state_next = ex_mem_write ? DONE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (dmem_resp_valid)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        stall_out      = 1'b0;
        misalign_fault = 1'b0;
        wb.valid       = 1'b0;
        wb.reg_write   = ex_reg_write;
        wb.mem_to_reg  = ex_mem_to_reg;
        wb.rd          = ex_rd;
        wb.alu_result  = ex_addr;
        wb.load_data   = '0;
        case (state_reg)
            IDLE: begin
                if (!mem_op) begin
                    wb.valid = ex_valid;
                end else if (misaligned) begin
                    misalign_fault = 1'b1;
                    wb.valid       = 1'b1;
                    wb.reg_write   = 1'b0;
                end else begin
                    dmem_req_valid = 1'b1;
                    stall_out      = 1'b1;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                stall_out      = 1'b1;
            end
            WAIT_RESP: stall_out = 1'b1;
            default: begin
                wb.valid     = 1'b1;
                wb.load_data = ex_mem_read ? load_reg : '0;
            end
        endcase
    end

    assign wb_valid      = wb.valid;
    assign wb_reg_write  = wb.reg_write;
    assign wb_mem_to_reg = wb.mem_to_reg;
    assign wb_rd         = wb.rd;
    assign wb_alu_result = wb.alu_result;
    assign wb_load_data  = wb.load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: drives loads/stores/ALU ops cycle by cycle and
// scoreboards every writeback bundle against bench-computed expectations.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   ex_addr, ex_store_data;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_to_reg;
    logic              dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [XLEN-1:0]   dmem_req_addr, dmem_req_wdata;
    logic [XLEN/8-1:0] dmem_req_wstrb;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_resp_rdata;
    logic              stall_out, wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_alu_result, wb_load_data;
    logic              misalign_fault;

    typedef struct {
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        fault;
        logic [63:0] alu;
        logic [63:0] ld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_funct3       (ex_funct3),
        .ex_addr         (ex_addr),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .stall_out       (stall_out),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_mem_to_reg   (wb_mem_to_reg),
        .wb_rd           (wb_rd),
        .wb_alu_result   (wb_alu_result),
        .wb_load_data    (wb_load_data),
        .misalign_fault  (misalign_fault)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Writeback monitor: every bundle the DUT emits must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("wb rd=%0d reg_write=%b fault=%b alu=%h load=%h",
                         wb_rd, wb_reg_write, misalign_fault, wb_alu_result, wb_load_data);
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_reg_write", 64'(wb_reg_write), 64'(e.reg_write));
                check("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(e.mem_to_reg));
                check("wb_fault", 64'(misalign_fault), 64'(e.fault));
                check("wb_alu_result", wb_alu_result, e.alu);
                check("wb_load_data", wb_load_data, e.ld);
            end
        end
    end

    task automatic drive_ex(input logic [4:0] rd, input logic rd_op, input logic wr_op,
                            input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sdata);
        ex_valid      = 1'b1;
        ex_mem_read   = rd_op;
        ex_mem_write  = wr_op;
        ex_funct3     = f3;
        ex_addr       = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = !wr_op;
        ex_mem_to_reg = rd_op;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Aligned memory op; called #1 after a rising edge, returns #1 after one.
    task automatic mem_op(input string name, input logic [4:0] rd, input logic is_store,
                          input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] sdata,
                          input int ready_low, input int resp_wait, input logic [63:0] rdata,
                          input logic [63:0] exp_ld, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata);
        exp_t e;
        $display("op %s addr=%h ready_low=%0d resp_wait=%0d", name, addr, ready_low, resp_wait);
        e.rd = rd; e.reg_write = !is_store; e.mem_to_reg = !is_store;
        e.fault = 1'b0; e.alu = addr; e.ld = is_store ? 64'd0 : exp_ld;
        sb.push_back(e);
        drive_ex(rd, !is_store, is_store, f3, addr, sdata);
        for (int i = 0; i <= ready_low; i++) begin
            dmem_req_ready  = (i == ready_low);
            // Stray responses before acceptance must not advance the load.
            dmem_resp_valid = !is_store && (i < ready_low);
            dmem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clk);
            check({name, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
            check({name, "_stall_req"}, 64'(stall_out), 64'd1);
            check({name, "_nowb_req"}, 64'(wb_valid), 64'd0);
            check({name, "_we"}, 64'(dmem_req_we), 64'(is_store));
            check({name, "_addr"}, dmem_req_addr, addr & ~64'h7);
            if (is_store) begin
                check({name, "_wstrb"}, 64'(dmem_req_wstrb), 64'(exp_strb));
                check({name, "_wdata"}, dmem_req_wdata, exp_wdata);
            end
            @(posedge clk); #1;
        end
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        if (!is_store) begin
            for (int j = 0; j <= resp_wait; j++) begin
                dmem_resp_valid = (j == resp_wait);
                dmem_resp_rdata = (j == resp_wait) ? rdata : 64'h5555_AAAA_5555_AAAA;
                @(negedge clk);
                check({name, "_req_off"}, 64'(dmem_req_valid), 64'd0);
                check({name, "_stall_wait"}, 64'(stall_out), 64'd1);
                check({name, "_nowb_wait"}, 64'(wb_valid), 64'd0);
                @(posedge clk); #1;
            end
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = 64'hFFFF_0000_FFFF_0000;
        end
        @(negedge clk);
        check({name, "_done_wb"}, 64'(wb_valid), 64'd1);
        check({name, "_done_stall"}, 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        idle_ex();
    endtask

    task automatic fault_op(input string name, input logic [4:0] rd, input logic is_store,
                            input logic [2:0] f3, input logic [63:0] addr);
        exp_t e;
        $display("op %s addr=%h (fault expected)", name, addr);
        e.rd = rd; e.reg_write = 1'b0; e.mem_to_reg = !is_store;
        e.fault = 1'b1; e.alu = addr; e.ld = 64'd0;
        sb.push_back(e);
        drive_ex(rd, !is_store, is_store, f3, addr, 64'h1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check({name, "_no_req"}, 64'(dmem_req_valid), 64'd0);
        check({name, "_no_stall"}, 64'(stall_out), 64'd0);
        check({name, "_wb"}, 64'(wb_valid), 64'd1);
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        idle_ex();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        idle_ex();
        ex_funct3 = 3'b000; ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_fault", 64'(misalign_fault), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ALU op passes through in the same cycle.
        $display("op alu rd=5");
        e.rd = 5; e.reg_write = 1'b1; e.mem_to_reg = 1'b0; e.fault = 1'b0;
        e.alu = 64'h1234; e.ld = 64'd0;
        sb.push_back(e);
        ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_rd = 5; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b0; ex_addr = 64'h1234;
        @(negedge clk);
        check("alu_stall", 64'(stall_out), 64'd0);
        check("alu_no_req", 64'(dmem_req_valid), 64'd0);
        check("alu_wb", 64'(wb_valid), 64'd1);
        @(posedge clk); #1;
        idle_ex();
        @(negedge clk);
        check("bubble_no_wb", 64'(wb_valid), 64'd0);
        @(posedge clk); #1;

        //      name    rd  st f3     addr          sdata                   rl rw rdata                   exp_ld                  strb   wdata
        mem_op("lb",    1, 0, F3_B,  64'h1003, 64'h0,                  0, 0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0);
        mem_op("sh",    2, 1, F3_H,  64'h2006, 64'h1234,               3, 0, 64'h0,                  64'h0,                  8'hC0, 64'h1234_1234_1234_1234);
        mem_op("lwu",   3, 0, F3_WU, 64'h4004, 64'h0,                  0, 2, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 8'h00, 64'h0);
        mem_op("lh",    4, 0, F3_H,  64'h100A, 64'h0,                  1, 0, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D, 8'h00, 64'h0);
        mem_op("lhu",   6, 0, F3_HU, 64'h100A, 64'h0,                  0, 1, 64'h0000_0000_F00D_0000, 64'h0000_0000_0000_F00D, 8'h00, 64'h0);
        mem_op("lw",    7, 0, F3_W,  64'h2000, 64'h0,                  0, 0, 64'h1111_1111_8765_4321, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0);
        mem_op("ld",    8, 0, F3_D,  64'h3008, 64'h0,                  2, 1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);
        mem_op("lbu",   9, 0, F3_BU, 64'h3007, 64'h0,                  0, 0, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 8'h00, 64'h0);
        mem_op("sb",   10, 1, F3_B,  64'h5005, 64'hFFFF_FFFF_FFFF_FF5A, 0, 0, 64'h0,                  64'h0,                  8'h20, 64'h5A5A_5A5A_5A5A_5A5A);
        mem_op("sw",   11, 1, F3_W,  64'h6004, 64'h1111_2222_CAFE_BABE, 1, 0, 64'h0,                  64'h0,                  8'hF0, 64'hCAFE_BABE_CAFE_BABE);
        mem_op("sd",   12, 1, F3_D,  64'h7000, 64'h0011_2233_4455_6677, 0, 0, 64'h0,                  64'h0,                  8'hFF, 64'h0011_2233_4455_6677);

        fault_op("lw_mis",  13, 0, F3_W,   64'h3002);
        fault_op("lh_mis",  14, 0, F3_H,   64'h1001);
        fault_op("ld_mis",  15, 0, F3_D,   64'h1004);
        fault_op("sd_mis",  16, 1, F3_D,   64'h7002);
        fault_op("f3_111",  17, 0, 3'b111, 64'h0000);

        // Reset while waiting for a load response; the late response is dropped.
        $display("op ld_reset addr=%h", 64'h8000);
        drive_ex(18, 1'b1, 1'b0, F3_D, 64'h8000, 64'h0);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check("rstw_req", 64'(dmem_req_valid), 64'd1);
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        reset = 1'b1;
        idle_ex();
        @(negedge clk);
        check("rstw_stall_wait", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h7777_7777_7777_7777;
        @(negedge clk);
        check("rstw_stall", 64'(stall_out), 64'd0);
        check("rstw_wb", 64'(wb_valid), 64'd0);
        check("rstw_req_off", 64'(dmem_req_valid), 64'd0);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        @(negedge clk);
        check("rstw_wb_after", 64'(wb_valid), 64'd0);
        check("rstw_stall_after", 64'(stall_out), 64'd0);
        @(posedge clk); #1;

        mem_op("lb_post", 19, 0, F3_B, 64'h9001, 64'h0, 0, 0, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F, 8'h00, 64'h0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
